instr_fetch_sequencer: RTL and testbench

- Upstream feeder for simple_processor_Top. Replaces the hand-timed bench stimulus on DIN/Run.
- Holds a small loadable program RAM and a program counter.
- Presents each instruction word on DIN. For mvi it also presents the following immediate word.
- Waits for the processor's Done pulse, then advances PC. Halts at a programmed end address or on timeout.

---
 rtl/instr_fetch_pkg.sv | 28 ++
 rtl/instr_fetch_sequencer_prog_ram.sv | 25 ++
 rtl/instr_fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_pkg;

  localparam int unsigned AW_DEF      = 4;
  localparam int unsigned IW_DEF      = 9;
  localparam int unsigned OPC_W       = 3;
  localparam int unsigned HOLD_DEF    = 2;
  localparam int unsigned TIMEOUT_DEF = 16;

  localparam logic [OPC_W-1:0] OP_MV  = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b010;
  localparam logic [OPC_W-1:0] OP_MVI = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    IMM,
    WAIT_DONE,
    HALT
  } fetch_state_t;

  // Opcode lives in the top three bits of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [IW_DEF-1:0] w);
    return w[IW_DEF-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer_prog_ram.sv
// Program store: one synchronous write port, one combinational read port.
module instr_fetch_sequencer_prog_ram
  import instr_fetch_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned IW = IW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [2**AW];

  // Write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Feeds instruction/immediate words to the processor and paces on its Done pulse.
module instr_fetch_sequencer
  import instr_fetch_pkg::*;
#(
  parameter int unsigned      AW          = AW_DEF,
  parameter int unsigned      IW          = IW_DEF,
  parameter int unsigned      HOLD_CYCLES = HOLD_DEF,
  parameter logic [OPC_W-1:0] MVI_OPCODE  = OP_MVI,
  parameter int unsigned      TIMEOUT     = TIMEOUT_DEF
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_wdata,
  input  logic [AW-1:0] end_addr,
  input  logic          Done,
  output logic [IW-1:0] DIN,
  output logic          Run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  fetch_state_t  state;
  logic [AW-1:0] end_q;
  logic [HW-1:0] hold_cnt;
  logic [WW-1:0] wait_cnt;
  logic          done_seen;
  logic          cur_mvi;

  logic [AW-1:0] rd_addr_c;
  logic [IW-1:0] rd_data_c;
  logic          ram_we_c;
  logic          hold_last_c;
  logic          is_last_c;

  // RAM is writable only while idle or halted, never while reset is held.
  assign ram_we_c    = prog_we && Resetn && ((state == IDLE) || (state == HALT));
  assign hold_last_c = (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign is_last_c   = (pc == end_q) || (cur_mvi && ((pc + AW'(1)) == end_q));

  // Read address anticipates the word loaded on the next state transition.
  always_comb begin
    rd_addr_c = '0;
    case (state)
      ISSUE, IMM: rd_addr_c = pc + AW'(1);
      WAIT_DONE:  rd_addr_c = cur_mvi ? (pc + AW'(2)) : (pc + AW'(1));
      default:    rd_addr_c = '0;
    endcase
  end

  instr_fetch_sequencer_prog_ram #(
    .AW(AW),
    .IW(IW)
  ) u_prog_ram (
    .clk  (Clock),
    .we   (ram_we_c),
    .waddr(prog_addr),
    .wdata(prog_wdata),
    .raddr(rd_addr_c),
    .rdata(rd_data_c)
  );

  // Sequencer FSM with registered DIN/Run/status outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      pc          <= '0;
      end_q       <= '0;
      DIN         <= '0;
      Run         <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      done_seen   <= 1'b0;
      cur_mvi     <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= ISSUE;
            pc          <= '0;
            end_q       <= end_addr;
            timeout_err <= 1'b0;
            DIN         <= rd_data_c;
            Run         <= 1'b1;
            busy        <= 1'b1;
            halted      <= 1'b0;
            hold_cnt    <= '0;
            done_seen   <= 1'b0;
          end
        end
        ISSUE: begin
          if (Done) done_seen <= 1'b1;
          if (hold_last_c) begin
            hold_cnt <= '0;
            wait_cnt <= '0;
            if (opcode_of(DIN) == MVI_OPCODE) begin
              state   <= IMM;
              DIN     <= rd_data_c;
              cur_mvi <= 1'b1;
            end else begin
              state   <= WAIT_DONE;
              cur_mvi <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        IMM: begin
          if (Done) done_seen <= 1'b1;
          if (hold_last_c) begin
            hold_cnt <= '0;
            wait_cnt <= '0;
            state    <= WAIT_DONE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        WAIT_DONE: begin
          if (Done || done_seen) begin
            done_seen <= 1'b0;
            if (is_last_c) begin
              state  <= HALT;
              DIN    <= '0;
              Run    <= 1'b0;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state    <= ISSUE;
              pc       <= rd_addr_c;
              DIN      <= rd_data_c;
              hold_cnt <= '0;
            end
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= HALT;
            DIN         <= '0;
            Run         <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: phase-level trace model plus literal pins.
module tb_instr_fetch_sequencer;
  import instr_fetch_pkg::*;

  localparam int H  = 2;
  localparam int TO = 16;

  logic       Clock = 1'b0;
  logic       Resetn, start, prog_we, Done;
  logic [3:0] prog_addr, end_addr, pc;
  logic [8:0] prog_wdata, DIN;
  logic       Run, busy, halted, timeout_err;

  always #5 Clock = ~Clock;

  instr_fetch_sequencer dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .end_addr   (end_addr),
    .Done       (Done),
    .DIN        (DIN),
    .Run        (Run),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [8:0] din;
    logic       run;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic       terr;
  } rec_t;

  rec_t       exp_q[$];
  bit         plan[$];
  int         dly[$];
  logic [8:0] mem[16];
  int         tests = 0;
  int         fails = 0;
  bit         cmp_go = 0;
  int         cyc = 0;
  int         we_cyc = -1;
  logic [3:0] we_a = 4'd0;
  logic [8:0] we_d = 9'd0;

  function automatic rec_t mk(input logic [8:0] d, input logic r, input logic [3:0] p,
                              input logic b, input logic h, input logic t);
    rec_t x;
    x.din = d; x.run = r; x.pc = p; x.busy = b; x.halted = h; x.terr = t;
    return x;
  endfunction

  // Single compare process: one expected record per cycle while a run is armed.
  always @(negedge Clock) begin
    rec_t e;
    if (cmp_go && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({DIN, Run, pc, busy, halted, timeout_err} !== e) begin
        fails++;
        $display("FAIL trace[%0d] got din=%h run=%b pc=%0d busy=%b halted=%b terr=%b want din=%h run=%b pc=%0d busy=%b halted=%b terr=%b",
                 cyc, DIN, Run, pc, busy, halted, timeout_err,
                 e.din, e.run, e.pc, e.busy, e.halted, e.terr);
      end
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [8:0] d);
    prog_addr = a; prog_wdata = d; prog_we = 1'b1;
    @(negedge Clock);
    prog_we = 1'b0;
    mem[a] = d;
  endtask

  // Expected trace from the rules: each instruction is H (or 2H for mvi) issue cycles,
  // then a wait whose length is set by when Done arrives, then HALT.
  task automatic build(input logic [3:0] e);
    int t = 0;
    int p, wl, d;
    logic [3:0] cpc = 4'd0;
    logic [8:0] w, imm, last;
    bit mvi, stop = 0, terr = 0;
    exp_q.delete(); plan.delete();
    while (!stop) begin
      w    = mem[cpc];
      mvi  = (w[8:6] == 3'b011);
      p    = mvi ? 2 * H : H;
      imm  = mem[cpc + 4'd1];
      last = mvi ? imm : w;
      for (int k = 0; k < H; k++) begin exp_q.push_back(mk(w, 1, cpc, 1, 0, 0)); plan.push_back(0); end
      if (mvi)
        for (int k = 0; k < H; k++) begin exp_q.push_back(mk(imm, 1, cpc, 1, 0, 0)); plan.push_back(0); end
      d = (dly.size() == 0) ? -1 : dly.pop_front();
      if (d < 0) begin wl = TO; terr = 1; stop = 1; end
      else wl = (d < p) ? 1 : d - p + 1;
      for (int k = 0; k < wl; k++) begin exp_q.push_back(mk(last, 1, cpc, 1, 0, 0)); plan.push_back(0); end
      if (d >= 0) plan[t + d] = 1;
      t += p + wl;
      if (cpc == e || (mvi && (cpc + 4'd1) == e)) stop = 1;
      if (!stop) cpc = cpc + (mvi ? 4'd2 : 4'd1);
    end
    for (int k = 0; k < 4; k++) begin exp_q.push_back(mk(9'd0, 0, cpc, 0, 1, terr)); plan.push_back(0); end
    plan[t + 1] = 1;
  endtask

  task automatic run(input logic [3:0] e);
    int n;
    build(e);
    n = exp_q.size();
    cyc = 0;
    end_addr = e; start = 1'b1;
    @(posedge Clock);
    cmp_go = 1;
    for (int t = 0; t < n; t++) begin
      @(negedge Clock);
      start      = (t == we_cyc);
      prog_we    = (t == we_cyc);
      prog_addr  = we_a;
      prog_wdata = we_d;
      Done       = plan[t];
    end
    #1;
    cmp_go = 0; Done = 1'b0; start = 1'b0; prog_we = 1'b0; we_cyc = -1;
    chk("trace_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    Resetn = 1'b0; start = 1'b0; prog_we = 1'b0; Done = 1'b0;
    prog_addr = '0; prog_wdata = '0; end_addr = '0;
    repeat (3) @(negedge Clock);
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_busy_halted_terr", {29'd0, busy, halted, timeout_err}, 32'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    // Reset while issuing; writes attempted during reset must not land.
    wr(4'd0, {OP_MV, 6'b001_010});
    end_addr = 4'd0; start = 1'b1;
    @(posedge Clock); #1 start = 1'b0;
    chk("issue_run", 32'(Run), 32'd1);
    chk("issue_din", 32'(DIN), 32'h00A);
    #1 Resetn = 1'b0;
    #1;
    chk("async_rst_run_din", {22'd0, Run, DIN}, 32'd0);
    chk("async_rst_pc_busy", {27'd0, pc, busy}, 32'd0);
    prog_addr = 4'd0; prog_wdata = 9'h0FF; prog_we = 1'b1;
    @(negedge Clock); @(negedge Clock);
    prog_we = 1'b0;
    @(negedge Clock); Resetn = 1'b1;
    @(negedge Clock);

    // end_addr=0: one instruction; Done during ISSUE shortens the wait.
    dly = '{1};
    run(4'd0);
    chk("one_instr_pc", 32'(pc), 32'd0);

    // mvi at 0 with immediate at 1, end_addr=1.
    wr(4'd0, 9'b011_000_001);
    wr(4'd1, 9'b111_110_000);
    dly = '{5};
    build(4'd1);
    chk("pin_t2_size", 32'(exp_q.size()), 32'd10);
    chk("pin_t2_w0", 32'(exp_q[1].din), 32'h0C1);
    chk("pin_t2_w1", 32'(exp_q[2].din), 32'h1F0);
    chk("pin_t2_halt", 32'(exp_q[6].halted), 32'd1);
    dly = '{5};
    run(4'd1);
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_pc", 32'(pc), 32'd0);

    // Three mvi plus sub; start/prog_we mid-run are ignored.
    wr(4'd0, {OP_MVI, 6'b000_000}); wr(4'd1, 9'd5);
    wr(4'd2, {OP_MVI, 6'b001_000}); wr(4'd3, 9'd7);
    wr(4'd4, {OP_MVI, 6'b010_000}); wr(4'd5, 9'd20);
    wr(4'd6, {OP_SUB, 6'b000_010});
    dly = '{5, 6, 4, 3};
    build(4'd6);
    chk("pin_t3_pc2", 32'(exp_q[6].pc), 32'd2);
    chk("pin_t3_sub", 32'(exp_q[18].din), 32'h082);
    chk("pin_t3_subwait", 32'(exp_q[20].din), 32'h082);
    chk("pin_t3_halt", 32'(exp_q[22].halted), 32'd1);
    dly = '{5, 6, 4, 3};
    we_cyc = 3; we_a = 4'd1; we_d = 9'h155;
    run(4'd6);
    chk("t3_pc", 32'(pc), 32'd6);
    dly = '{5, 6, 4, 3};
    run(4'd6);

    // Done during ISSUE of non-mvi instructions.
    wr(4'd0, {OP_MV, 6'b000_001});
    wr(4'd1, {OP_ADD, 6'b001_000});
    wr(4'd2, {OP_SUB, 6'b010_001});
    dly = '{0, 1, 4};
    build(4'd2);
    chk("pin_t4_wait_pc", 32'(exp_q[2].pc), 32'd0);
    chk("pin_t4_next_pc", 32'(exp_q[3].pc), 32'd1);
    dly = '{0, 1, 4};
    run(4'd2);

    // Timeout, then restart clears the error.
    dly.delete();
    run(4'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_halt_run", {30'd0, halted, Run}, 32'd2);
    dly = '{2};
    run(4'd0);
    chk("to_cleared", 32'(timeout_err), 32'd0);

    // PC wrap: mvi at 15 fetches its immediate from address 0.
    wr(4'd0, {OP_MV, 6'b011_100});
    for (int i = 1; i < 14; i += 2) begin
      wr(4'(i), {OP_MVI, 6'b000_000});
      wr(4'(i + 1), 9'(i + 1));
    end
    wr(4'd15, {OP_MVI, 6'b111_000});
    dly = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run(4'd15);
    chk("wrap_pc", 32'(pc), 32'd15);
    chk("wrap_halted", 32'(halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
